mc_axi_tgen_chk: RTL and testbench

AXI4 traffic generator and checker that drives the `iafu2mc_to_mc_axi4` request port of `mc_top` and consumes `mc2iafu_from_mc_axi4`. It sits directly upstream of the memory controller, in place of the IAFU, for bring-up and simulation. It writes a programmable number of single-beat, address-derived data patterns, reads them back, compares the read data, and reports pass, fail or timeout.

---
 rtl/mc_axi_tgen_chk.sv | 255 +++++++++++++++++++++++++
 tb/tb_mc_axi_tgen_chk.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_axi_tgen_chk.sv
`timescale 1ns/1ps
// AXI4 bring-up traffic generator/checker for mc_top: writes address-derived patterns, reads them
// back one transaction at a time, and reports pass/fail/timeout.
package mc_axi_if_pkg;
  localparam int unsigned McAxiDataW = 512;
  localparam int unsigned McAxiAddrW = 52;
  localparam int unsigned McAxiIdW   = 8;

  typedef struct packed {
    logic [McAxiIdW-1:0]     awid;
    logic [McAxiAddrW-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [McAxiDataW-1:0]   wdata;
    logic [McAxiDataW/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [McAxiIdW-1:0]     arid;
    logic [McAxiAddrW-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } t_to_mc_axi4;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [McAxiIdW-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [McAxiIdW-1:0]   rid;
    logic [McAxiDataW-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } t_from_mc_axi4;
endpackage

module mc_axi_tgen_chk
  import mc_axi_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 52,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned ADDR_STRIDE    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 ip2hdm_clk,
  input  logic                 ip2hdm_reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_txn,
  input  logic [31:0]          seed,
  output t_to_mc_axi4          to_mc,
  input  t_from_mc_axi4        from_mc,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] first_err_idx
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StWrAddrData = 3'd1;
  localparam logic [2:0] StWrResp     = 3'd2;
  localparam logic [2:0] StRdAddr     = 3'd3;
  localparam logic [2:0] StRdData     = 3'd4;
  localparam logic [2:0] StDone       = 3'd5;

  localparam logic [2:0] AxSize = 3'($clog2(DATA_WIDTH / 8));
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  // done/timeout becomes visible TIMEOUT_CYCLES cycles after the request handshake
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);

  logic [2:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  i_q, i_d, num_q, num_d;
  logic [31:0]           seed_q, seed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, first_err_q, first_err_d;
  logic                  timeout_q, timeout_d, done_q, done_d;
  logic                  rec_err, last;
  logic [31:0]           pat_word;
  logic [DATA_WIDTH-1:0] pat_data;
  logic                  unused_from_mc;

  assign last     = (i_q == num_q - 1'b1);
  assign pat_word = 32'(i_q) ^ seed_q;
  assign pat_data = {(DATA_WIDTH / 32){pat_word}};
  assign unused_from_mc = ^{from_mc.bid, from_mc.rid, from_mc.rlast};

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    num_d       = num_q;
    seed_d      = seed_q;
    addr_d      = addr_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    tmo_cnt_d   = '0;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    done_d      = done_q;
    rec_err     = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_d       = num_txn;
          seed_d      = seed;
          i_d         = '0;
          addr_d      = BASE_ADDR;
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          if (num_txn == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d   = StWrAddrData;
            done_d    = 1'b0;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
        end
      end
      StWrAddrData: begin
        if (from_mc.awready) aw_pend_d = 1'b0;
        if (from_mc.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = StWrResp;
      end
      StWrResp: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (from_mc.bvalid) begin
          rec_err   = (from_mc.bresp != 2'b00);
          tmo_cnt_d = '0;
          if (last) begin
            i_d     = '0;
            addr_d  = BASE_ADDR;
            state_d = StRdAddr;
          end else begin
            i_d       = i_q + 1'b1;
            addr_d    = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = StWrAddrData;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      StRdAddr: begin
        if (from_mc.arready) state_d = StRdData;
      end
      StRdData: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (from_mc.rvalid) begin
          rec_err   = (from_mc.rresp != 2'b00) || (from_mc.rdata != pat_data);
          tmo_cnt_d = '0;
          if (last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            i_d     = i_q + 1'b1;
            addr_d  = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
            state_d = StRdAddr;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rec_err) begin
      if (err_cnt_q == '0) first_err_d = i_q;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ip2hdm_clk or posedge ip2hdm_reset) begin
    if (ip2hdm_reset) begin
      state_q     <= StIdle;
      i_q         <= '0;
      num_q       <= '0;
      seed_q      <= '0;
      addr_q      <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      num_q       <= num_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
    end
  end

  // Payload is a function of state and index only, so it is stable while a valid waits.
  always_comb begin
    to_mc = '0;
    case (state_q)
      StWrAddrData: begin
        to_mc.awvalid = aw_pend_q;
        to_mc.awaddr  = addr_q;
        to_mc.awsize  = AxSize;
        to_mc.awburst = 2'b01;
        to_mc.wvalid  = w_pend_q;
        to_mc.wdata   = pat_data;
        to_mc.wstrb   = '1;
        to_mc.wlast   = 1'b1;
      end
      StWrResp: to_mc.bready = 1'b1;
      StRdAddr: begin
        to_mc.arvalid = 1'b1;
        to_mc.araddr  = addr_q;
        to_mc.arsize  = AxSize;
        to_mc.arburst = 2'b01;
      end
      StRdData: to_mc.rready = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state_q != StIdle) && (state_q != StDone);
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign pass          = done_q && (err_cnt_q == '0) && !timeout_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_mc_axi_tgen_chk.sv
`timescale 1ns/1ps
// Bench for mc_axi_tgen_chk: table of runs against a behavioral AXI slave with a memory, plus
// hand-written timeout and mid-run reset sequences; AW/W/AR traffic is scoreboarded.
module tb_mc_axi_tgen_chk;
  import mc_axi_if_pkg::*;

  localparam int unsigned CntW  = 16;
  localparam int unsigned DataW = 512;
  localparam int unsigned Tmo   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CntW-1:0] num_txn = '0;
  logic [31:0]     seed = '0;
  t_to_mc_axi4     to_mc;
  t_from_mc_axi4   from_mc;
  logic            busy, done, pass, timeout;
  logic [CntW-1:0] err_cnt, first_err_idx;

  mc_axi_tgen_chk #(
    .DATA_WIDTH    (DataW),
    .ADDR_WIDTH    (52),
    .BASE_ADDR     (52'h0),
    .ADDR_STRIDE   (64),
    .TIMEOUT_CYCLES(Tmo),
    .CNT_WIDTH     (CntW)
  ) dut (
    .ip2hdm_clk   (clk),
    .ip2hdm_reset (rst),
    .start        (start),
    .num_txn      (num_txn),
    .seed         (seed),
    .to_mc        (to_mc),
    .from_mc      (from_mc),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder configuration, written by the main sequence.
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_corrupt = -1, cfg_berr = -1, cfg_rerr = -1;
  bit cfg_no_r = 1'b0;
  logic resp_clr = 1'b0;

  // Responder state.
  int              aw_cnt, w_cnt, wr_idx, rd_idx;
  logic            aw_got, w_got, aw_hs, w_hs;
  logic [51:0]     aw_addr_h, addr_now;
  logic [DataW-1:0] w_data_h, data_now, rd;
  logic            bvalid_r, rvalid_r;
  logic [1:0]      bresp_r, rresp_r;
  logic [DataW-1:0] rdata_r;
  logic [DataW-1:0] mem [logic [51:0]];
  logic            aw_rdy, w_rdy;

  assign aw_rdy = (aw_cnt >= cfg_aw_dly);
  assign w_rdy  = (w_cnt >= cfg_w_dly);

  always_comb begin
    from_mc         = '0;
    from_mc.awready = aw_rdy;
    from_mc.wready  = w_rdy;
    from_mc.arready = 1'b1;
    from_mc.bvalid  = bvalid_r;
    from_mc.bresp   = bresp_r;
    from_mc.rvalid  = rvalid_r;
    from_mc.rresp   = rresp_r;
    from_mc.rdata   = rdata_r;
    from_mc.rlast   = rvalid_r;
  end

  always @(posedge clk or posedge rst) begin
    if (rst || resp_clr) begin
      aw_cnt <= 0; w_cnt <= 0; wr_idx <= 0; rd_idx <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      bresp_r <= 2'b00; rresp_r <= 2'b00; rdata_r <= '0;
      mem.delete();
    end else begin
      aw_hs = to_mc.awvalid && aw_rdy;
      w_hs  = to_mc.wvalid && w_rdy;
      if (aw_hs) begin aw_cnt <= 0; aw_addr_h <= to_mc.awaddr; end
      else if (to_mc.awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_cnt <= 0; w_data_h <= to_mc.wdata; end
      else if (to_mc.wvalid) w_cnt <= w_cnt + 1;
      addr_now = aw_hs ? to_mc.awaddr : aw_addr_h;
      data_now = w_hs ? to_mc.wdata : w_data_h;
      if (bvalid_r) begin
        if (to_mc.bready) begin bvalid_r <= 1'b0; wr_idx <= wr_idx + 1; end
      end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[addr_now] = data_now;
        bvalid_r <= 1'b1;
        bresp_r  <= (wr_idx == cfg_berr) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (rvalid_r) begin
        if (to_mc.rready) begin rvalid_r <= 1'b0; rd_idx <= rd_idx + 1; end
      end else if (to_mc.arvalid && !cfg_no_r) begin
        rd = mem.exists(to_mc.araddr) ? mem[to_mc.araddr] : '0;
        if (rd_idx == cfg_corrupt) rd[7] = ~rd[7];
        rdata_r  <= rd;
        rresp_r  <= (rd_idx == cfg_rerr) ? 2'b10 : 2'b00;
        rvalid_r <= 1'b1;
      end
    end
  end

  // Scoreboard queues filled when a run is launched, drained by the bus monitor.
  logic [51:0]      exp_aw_q [$];
  logic [51:0]      exp_ar_q [$];
  logic [DataW-1:0] exp_w_q  [$];

  logic             prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_w_hs = 1'b0;
  logic             prev_ar_stall = 1'b0;
  logic [51:0]      prev_awaddr, prev_araddr, exp_a;
  logic [DataW-1:0] prev_wdata, exp_d;
  int unsigned      ar_hs_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_w_hs = 1'b0; prev_ar_stall = 1'b0;
    end else begin
      if (prev_aw_stall) check("aw_stable", {to_mc.awvalid, to_mc.awaddr}, {1'b1, prev_awaddr});
      if (prev_ar_stall) check("ar_stable", {to_mc.arvalid, to_mc.araddr}, {1'b1, prev_araddr});
      if (prev_w_hs) check("w_drop", 64'(to_mc.wvalid), 64'd0);
      if (prev_w_stall) begin
        checks++;
        if (!to_mc.wvalid || to_mc.wdata !== prev_wdata) begin
          errors++;
          $display("FAIL w_stable: wvalid=%0b wdata changed=%0b", to_mc.wvalid,
                   to_mc.wdata !== prev_wdata);
        end
      end
      if (to_mc.awvalid && from_mc.awready) begin
        if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(to_mc.awaddr), 64'hDEAD);
        else begin
          exp_a = exp_aw_q.pop_front();
          check("awaddr", 64'(to_mc.awaddr), 64'(exp_a));
        end
        check("aw_attr", {to_mc.awid, to_mc.awlen, to_mc.awsize, to_mc.awburst},
              {8'd0, 8'd0, 3'd6, 2'b01});
      end
      if (to_mc.wvalid && from_mc.wready) begin
        checks++;
        if (exp_w_q.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: got 0x%0h, expected no write data", to_mc.wdata[31:0]);
        end else begin
          exp_d = exp_w_q.pop_front();
          if (to_mc.wdata !== exp_d) begin
            errors++;
            $display("FAIL wdata: got 0x%0h, expected 0x%0h", to_mc.wdata, exp_d);
          end
        end
        check("wstrb_wlast", {&to_mc.wstrb, to_mc.wlast}, 64'd3);
      end
      if (to_mc.arvalid && from_mc.arready) begin
        ar_hs_cyc = cyc;
        if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(to_mc.araddr), 64'hDEAD);
        else begin
          exp_a = exp_ar_q.pop_front();
          check("araddr", 64'(to_mc.araddr), 64'(exp_a));
        end
      end
      prev_aw_stall = to_mc.awvalid && !from_mc.awready;
      prev_w_stall  = to_mc.wvalid && !from_mc.wready;
      prev_ar_stall = to_mc.arvalid && !from_mc.arready;
      prev_w_hs     = to_mc.wvalid && from_mc.wready;
      prev_awaddr   = to_mc.awaddr;
      prev_araddr   = to_mc.araddr;
      prev_wdata    = to_mc.wdata;
    end
  end

  typedef struct {
    int          num;
    logic [31:0] seed;
    int          aw_dly;
    int          w_dly;
    int          corrupt;
    int          berr;
    int          rerr;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
  } vec_t;

  vec_t vecs [6];

  task automatic clr_responder();
    @(posedge clk); #1 resp_clr = 1'b1;
    @(posedge clk); #1 resp_clr = 1'b0;
  endtask

  task automatic push_exp(input int n_wr, input int n_rd, input logic [31:0] s);
    for (int i = 0; i < n_wr; i++) begin
      exp_aw_q.push_back(52'(i * 64));
      exp_w_q.push_back({16{32'(i) ^ s}});
    end
    for (int i = 0; i < n_rd; i++) exp_ar_q.push_back(52'(i * 64));
  endtask

  task automatic pulse_start(input int n, input logic [31:0] s);
    num_txn = CntW'(n);
    seed    = s;
    start   = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_corrupt = v.corrupt;
    cfg_berr = v.berr; cfg_rerr = v.rerr; cfg_no_r = 1'b0;
    clr_responder();
    push_exp(v.num, v.num, v.seed);
    pulse_start(v.num, v.seed);
    if (v.num == 0) begin
      check({tag, "_zero_done"}, {done, pass, busy}, 64'b110);
    end else begin
      check({tag, "_start"}, {busy, to_mc.awvalid, to_mc.wvalid, done}, 64'b1110);
    end
    wait_done(400, tag);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(v.exp_err));
    check({tag, "_first_err"}, 64'(first_err_idx), 64'(v.exp_first));
    check({tag, "_pass_tmo"}, {pass, timeout}, {v.exp_pass, 1'b0});
    check({tag, "_sb_drain"}, 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 32'hA5A5_0000, 0, 0, -1, -1, -1, 0, 0, 1'b1};
    vecs[1] = '{3, 32'h1234_5678, 3, 0, -1, -1, -1, 0, 0, 1'b1};
    vecs[2] = '{3, 32'h0000_0000, 0, 3, -1, -1, -1, 0, 0, 1'b1};
    vecs[3] = '{5, 32'hDEAD_BEEF, 0, 0, 2, -1, -1, 1, 2, 1'b0};
    vecs[4] = '{5, 32'h0F0F_0000, 0, 0, -1, 0, 3, 2, 0, 1'b0};
    vecs[5] = '{0, 32'h0000_0001, 0, 0, -1, -1, -1, 0, 0, 1'b1};

    #12;
    check("reset_status", {busy, done, pass, timeout}, 64'd0);
    check("reset_counts", {err_cnt, first_err_idx}, 64'd0);
    checks++;
    if (to_mc !== '0) begin
      errors++;
      $display("FAIL reset_to_mc: got nonzero bus, expected all zero");
    end
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Read response never arrives.
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_corrupt = -1; cfg_berr = -1; cfg_rerr = -1;
    cfg_no_r = 1'b1;
    clr_responder();
    push_exp(2, 1, 32'h1111_0000);
    pulse_start(2, 32'h1111_0000);
    wait_done(200, "tmo");
    check("tmo_latency", 64'(cyc - ar_hs_cyc), 64'(Tmo));
    check("tmo_flags", {timeout, pass, busy}, 64'b100);
    check("tmo_bus_idle", {to_mc.awvalid, to_mc.wvalid, to_mc.arvalid, to_mc.bready,
                           to_mc.rready}, 64'd0);
    check("tmo_sb_drain", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'd0);

    // Reset while waiting in the read-data phase, then a zero-length run.
    clr_responder();
    push_exp(1, 1, 32'h0000_0007);
    pulse_start(1, 32'h0000_0007);
    repeat (6) @(posedge clk);
    #1 check("pre_reset_rd_wait", {busy, to_mc.rready}, 64'b11);
    #2 rst = 1'b1;
    #1 check("midrst_status", {busy, done, pass, timeout}, 64'd0);
    check("midrst_counts", {err_cnt, first_err_idx}, 64'd0);
    checks++;
    if (to_mc !== '0) begin
      errors++;
      $display("FAIL midrst_to_mc: got nonzero bus, expected all zero");
    end
    check("midrst_sb_drain", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cfg_no_r = 1'b0;
    @(posedge clk); #1;
    pulse_start(0, 32'h0);
    check("post_rst_zero_run", {done, pass, busy, timeout}, 64'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
